// File: rtl/irq_sequencer.sv
// Interrupt sequencer: filters and latches /NMI edges, samples the /IRQ level, and arbitrates
// reset/NMI/IRQ/BRK at CPU poll points. The chosen vector stays frozen until the core acks.
module irq_sequencer #(
  parameter logic [15:0] RST_VEC  = 16'hFFFC,
  parameter logic [15:0] NMI_VEC  = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC  = 16'hFFFE,
  parameter int unsigned NMI_FILT = 2
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_nmi_n,
  input  logic        I_irq_n,
  input  logic        I_imask,
  input  logic        I_brk,
  input  logic        I_poll,
  input  logic        I_ack,
  output logic        O_take,
  output logic [15:0] O_vector,
  output logic [1:0]  O_kind,
  output logic        O_nmi_pend
);

  localparam logic [3:0] FiltMax = 4'(NMI_FILT);
  localparam logic [3:0] FiltM1  = 4'(NMI_FILT - 1);

  localparam logic [1:0] KindRst = 2'd0;
  localparam logic [1:0] KindNmi = 2'd1;
  localparam logic [1:0] KindIrq = 2'd2;
  localparam logic [1:0] KindBrk = 2'd3;

  typedef enum logic [1:0] {StRstPend, StIdle, StService} state_e;

  state_e      state_q, state_d;
  logic [15:0] vector_q, vector_d;
  logic [1:0]  kind_q, kind_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        nmi_q, nmi_d;
  logic        nmi_set;
  logic        irq_ok;
  logic        nmi_ack;

  // The latch sets on the same edge at which the counter reaches NMI_FILT.
  assign nmi_set = ~I_nmi_n & armed_q & (cnt_q >= FiltM1);
  assign irq_ok  = ~I_irq_n & ~I_imask;
  assign nmi_ack = (state_q == StService) & I_ack & (kind_q == KindNmi);

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (I_nmi_n) begin
      cnt_d   = 4'd0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q < FiltMax) cnt_d = cnt_q + 4'd1;
      if (nmi_set) armed_d = 1'b0;
    end
  end

  // A new qualifying edge beats the clearing ack so it is never lost.
  always_comb begin
    nmi_d = nmi_q;
    if (nmi_set) begin
      nmi_d = 1'b1;
    end else if (nmi_ack) begin
      nmi_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    kind_d   = kind_q;
    unique case (state_q)
      StRstPend: begin
        if (I_poll) begin
          state_d  = StService;
          vector_d = RST_VEC;
          kind_d   = KindRst;
        end
      end
      StIdle: begin
        // Uses the registered latch, so an edge qualifying this cycle waits for the next poll.
        if (I_poll) begin
          if (nmi_q) begin
            state_d  = StService;
            vector_d = NMI_VEC;
            kind_d   = KindNmi;
          end else if (irq_ok) begin
            state_d  = StService;
            vector_d = IRQ_VEC;
            kind_d   = KindIrq;
          end else if (I_brk) begin
            state_d  = StService;
            vector_d = IRQ_VEC;
            kind_d   = KindBrk;
          end
        end
      end
      StService: begin
        if (I_ack) state_d = StIdle;
      end
      default: state_d = StRstPend;
    endcase
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q  <= StRstPend;
      vector_q <= RST_VEC;
      kind_q   <= KindRst;
      cnt_q    <= 4'd0;
      armed_q  <= 1'b1;
      nmi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      nmi_q    <= nmi_d;
    end
  end

  assign O_take     = (state_q == StService);
  assign O_vector   = vector_q;
  assign O_kind     = kind_q;
  assign O_nmi_pend = nmi_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer (NMI_FILT=2) with hand-computed expected values.
module tb_irq_sequencer;

  logic        I_clock = 1'b0;
  logic        I_reset = 1'b0;
  logic        I_nmi_n = 1'b1;
  logic        I_irq_n = 1'b1;
  logic        I_imask = 1'b1;
  logic        I_brk   = 1'b0;
  logic        I_poll  = 1'b0;
  logic        I_ack   = 1'b0;
  logic        O_take;
  logic [15:0] O_vector;
  logic [1:0]  O_kind;
  logic        O_nmi_pend;

  int n_cmp = 0;
  int n_err = 0;

  irq_sequencer #(
    .RST_VEC (16'hFFFC),
    .NMI_VEC (16'hFFFA),
    .IRQ_VEC (16'hFFFE),
    .NMI_FILT(2)
  ) dut (
    .I_clock   (I_clock),
    .I_reset   (I_reset),
    .I_nmi_n   (I_nmi_n),
    .I_irq_n   (I_irq_n),
    .I_imask   (I_imask),
    .I_brk     (I_brk),
    .I_poll    (I_poll),
    .I_ack     (I_ack),
    .O_take    (O_take),
    .O_vector  (O_vector),
    .O_kind    (O_kind),
    .O_nmi_pend(O_nmi_pend)
  );

  always #5 I_clock = ~I_clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge I_clock);
    #1;
  endtask

  task automatic do_poll();
    I_poll = 1'b1;
    tick();
    I_poll = 1'b0;
  endtask

  task automatic do_ack();
    I_ack = 1'b1;
    tick();
    I_ack = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_take", 16'(O_take), 16'd0);
    check("rst_vec", O_vector, 16'hFFFC);
    check("rst_kind", 16'(O_kind), 16'd0);
    check("rst_pend", 16'(O_nmi_pend), 16'd0);
    I_reset = 1'b1;
    tick();

    // Reset service
    do_poll();
    check("rsv_take", 16'(O_take), 16'd1);
    check("rsv_vec", O_vector, 16'hFFFC);
    check("rsv_kind", 16'(O_kind), 16'd0);
    do_poll();
    check("rsv_poll_ignored", 16'(O_take), 16'd1);
    do_ack();
    check("rsv_ack_take", 16'(O_take), 16'd0);
    do_poll();
    check("idle_nosrc", 16'(O_take), 16'd0);
    do_ack();
    check("idle_ack_noop", 16'(O_take), 16'd0);

    // NMI glitch shorter than the filter
    I_nmi_n = 1'b0;
    tick();
    I_nmi_n = 1'b1;
    tick();
    check("glitch_pend", 16'(O_nmi_pend), 16'd0);

    // Qualified NMI edge
    I_nmi_n = 1'b0;
    tick();
    check("nmi_cnt1_pend", 16'(O_nmi_pend), 16'd0);
    tick();
    check("nmi_cnt2_pend", 16'(O_nmi_pend), 16'd1);
    tick();
    tick();
    tick();
    do_poll();
    check("nmi_take", 16'(O_take), 16'd1);
    check("nmi_vec", O_vector, 16'hFFFA);
    check("nmi_kind", 16'(O_kind), 16'd1);
    do_ack();
    check("nmi_ack_take", 16'(O_take), 16'd0);
    check("nmi_ack_pend", 16'(O_nmi_pend), 16'd0);
    tick();
    tick();
    check("nmi_once_pend", 16'(O_nmi_pend), 16'd0);
    do_poll();
    check("nmi_once_take", 16'(O_take), 16'd0);
    I_nmi_n = 1'b1;
    tick();

    // IRQ masking and priority over BRK
    I_irq_n = 1'b0;
    I_imask = 1'b1;
    do_poll();
    check("irq_masked", 16'(O_take), 16'd0);
    I_imask = 1'b0;
    do_poll();
    check("irq_take", 16'(O_take), 16'd1);
    check("irq_vec", O_vector, 16'hFFFE);
    check("irq_kind", 16'(O_kind), 16'd2);
    do_ack();
    I_brk = 1'b1;
    do_poll();
    check("irq_over_brk", 16'(O_kind), 16'd2);
    do_ack();
    I_irq_n = 1'b1;
    do_poll();
    check("brk_kind", 16'(O_kind), 16'd3);
    check("brk_vec", O_vector, 16'hFFFE);
    do_ack();
    I_brk = 1'b0;

    // NMI beats IRQ, IRQ served after
    I_irq_n = 1'b0;
    I_nmi_n = 1'b0;
    tick();
    tick();
    check("both_pend", 16'(O_nmi_pend), 16'd1);
    do_poll();
    check("both_kind_nmi", 16'(O_kind), 16'd1);
    do_ack();
    do_poll();
    check("both_kind_irq", 16'(O_kind), 16'd2);
    do_ack();
    I_irq_n = 1'b1;
    I_nmi_n = 1'b1;
    tick();

    // Second NMI qualifying on the same edge as the clearing ack
    I_nmi_n = 1'b0;
    tick();
    tick();
    do_poll();
    check("nmi2_kind", 16'(O_kind), 16'd1);
    I_nmi_n = 1'b1;
    tick();
    I_nmi_n = 1'b0;
    tick();
    do_ack();
    check("nmi2_ack_take", 16'(O_take), 16'd0);
    check("nmi2_set_wins", 16'(O_nmi_pend), 16'd1);
    do_poll();
    check("nmi2_again_take", 16'(O_take), 16'd1);
    check("nmi2_again_kind", 16'(O_kind), 16'd1);
    do_ack();
    check("nmi2_cleared", 16'(O_nmi_pend), 16'd0);
    I_nmi_n = 1'b1;
    tick();

    // NMI during BRK service keeps the frozen vector; then async reset mid-service
    I_brk = 1'b1;
    do_poll();
    I_brk = 1'b0;
    I_nmi_n = 1'b0;
    tick();
    tick();
    check("brk_nmi_pend", 16'(O_nmi_pend), 16'd1);
    check("brk_frozen_kind", 16'(O_kind), 16'd3);
    check("brk_frozen_vec", O_vector, 16'hFFFE);
    #2;
    I_reset = 1'b0;
    #1;
    check("arst_take", 16'(O_take), 16'd0);
    check("arst_vec", O_vector, 16'hFFFC);
    check("arst_kind", 16'(O_kind), 16'd0);
    check("arst_pend", 16'(O_nmi_pend), 16'd0);
    I_nmi_n = 1'b1;
    tick();
    I_reset = 1'b1;
    tick();
    do_poll();
    check("post_rst_take", 16'(O_take), 16'd1);
    check("post_rst_kind", 16'(O_kind), 16'd0);
    check("post_rst_vec", O_vector, 16'hFFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
